// File: rtl/i_deser.sv
// rtl/i_deser.sv - input-side serial-to-parallel deserializer with bitslip alignment
// A slip freezes the bit counter for one sample, moving the word boundary one bit later.
module i_deser #(
    parameter logic [127:0] IOSTANDARD = "DEFAULT",
    parameter int           WIDTH      = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     D,
    input  logic                     EN,
    input  logic                     BITSLIP,
    output logic [WIDTH-1:0]         Q,
    output logic                     DATA_VALID,
    output logic                     BITSLIP_BUSY,
    output logic [$clog2(WIDTH)-1:0] SLIP_CNT
);

    localparam int CW = $clog2(WIDTH);

    function automatic bit has_pfx(input logic [127:0] s, input logic [127:0] p, input int plen);
        int slen;
        slen = 0;
        for (int i = 0; i < 16; i++) begin
            if (s[i*8 +: 8] != 8'd0) slen = i + 1;
        end
        return (slen > plen) && ((s >> ((slen - plen) * 8)) == p);
    endfunction

    function automatic bit iostd_ok(input logic [127:0] s);
        return (s == 128'("DEFAULT")) || (s == 128'("LVTTL")) || (s == 128'("HSUL_12")) ||
               (s == 128'("PCI66"))   || (s == 128'("PCIX133")) || (s == 128'("POD_12")) ||
               has_pfx(s, 128'("LVCMOS_"), 7) || has_pfx(s, 128'("HSTL_"), 5) ||
               has_pfx(s, 128'("SSTL_"), 5);
    endfunction

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $fatal(1, "%m: WIDTH=%0d is illegal; legal range is 3..10", WIDTH);
    end

    if (!iostd_ok(IOSTANDARD)) begin : g_bad_iostd
        $fatal(1, "%m: IOSTANDARD \"%s\" is illegal; valid: DEFAULT, LVCMOS_*, LVTTL, HSTL_*, HSUL_12, PCI66, PCIX133, POD_12, SSTL_*",
               IOSTANDARD);
    end

    typedef enum logic [1:0] {IDLE, SLIP_PEND, SLIP_GUARD} state_t;

    state_t          state, state_d;
    logic            guard_seen, guard_seen_d;
    logic            bs_q;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]   cnt;
    logic            slip_edge, freeze, word_done;

    always_comb begin
        state_d      = state;
        guard_seen_d = guard_seen;
        slip_edge    = BITSLIP & ~bs_q;
        freeze       = EN && (state == SLIP_PEND);
        word_done    = EN && !freeze && (cnt == CW'(WIDTH - 1));
        if (EN) begin
            case (state)
                IDLE: if (slip_edge) state_d = SLIP_PEND;
                SLIP_PEND: begin
                    state_d      = SLIP_GUARD;
                    guard_seen_d = 1'b0;
                end
                SLIP_GUARD: if (word_done) begin
                    if (guard_seen) state_d = IDLE;
                    else            guard_seen_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            guard_seen <= 1'b0;
            bs_q       <= 1'b0;
            sh         <= '0;
            cnt        <= '0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
            SLIP_CNT   <= '0;
        end else begin
            state      <= state_d;
            guard_seen <= guard_seen_d;
            DATA_VALID <= 1'b0;
            if (EN) begin
                bs_q <= BITSLIP;
                sh   <= {sh[WIDTH-2:0], D};
                if (!freeze) cnt <= (cnt == CW'(WIDTH - 1)) ? '0 : cnt + 1'b1;
                if (word_done) begin
                    Q          <= {sh[WIDTH-2:0], D};
                    DATA_VALID <= 1'b1;
                end
                if (freeze) SLIP_CNT <= (SLIP_CNT == CW'(WIDTH - 1)) ? '0 : SLIP_CNT + 1'b1;
            end
        end
    end

    assign BITSLIP_BUSY = (state != IDLE);

endmodule

// File: tb/tb_i_deser.sv
// tb/tb_i_deser.sv - self-checking bench for i_deser
// Table of per-cycle vectors for framing, directed sequences for slip and reset corners.
module tb_i_deser;

    logic       CLK = 1'b0;
    logic       RST, D, EN, BITSLIP;
    logic [3:0] Q;
    logic       DATA_VALID, BITSLIP_BUSY;
    logic [1:0] SLIP_CNT;

    int n_checks = 0;
    int n_fail   = 0;
    int idx      = 0;
    logic [3:0] pat_v = 4'b1100;

    typedef struct {
        logic       d;
        logic       en;
        logic [3:0] q;
        logic       dv;
    } vec_t;
    vec_t tbl[16];

    i_deser #(.IOSTANDARD("LVCMOS_18"), .WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .D(D), .EN(EN), .BITSLIP(BITSLIP),
        .Q(Q), .DATA_VALID(DATA_VALID), .BITSLIP_BUSY(BITSLIP_BUSY), .SLIP_CNT(SLIP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic d, input logic en, input logic bs);
        D = d; EN = en; BITSLIP = bs;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic bs);
        drive(pat_v[3 - (idx % 4)], 1'b1, bs);
        idx++;
    endtask

    task automatic do_slip(input int pre, input int lat, input logic [3:0] word,
                           input logic [1:0] cnt, input logic [3:0] prev, input bit hold);
        int ndv;
        bit done;
        ndv  = 0;
        done = 0;
        for (int i = 0; i < pre; i++) send(1'b0);
        send(1'b1);
        chk("busy_set", BITSLIP_BUSY, 1);
        if (pre == 3) begin
            chk("coincide_dv", DATA_VALID, 1);
            chk("coincide_q", Q, prev);
        end
        for (int n = 1; n <= 24 && !done; n++) begin
            send(hold && ndv >= 1);
            if (DATA_VALID) begin
                ndv++;
                if (ndv == 1) chk("slip_latency", n, lat);
                chk("slip_word", Q, word);
            end
            if (!BITSLIP_BUSY) done = 1;
        end
        chk("slip_done", done, 1);
        chk("guard_dvs", ndv, 2);
        chk("slip_cnt", SLIP_CNT, cnt);
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                send(1'b1);
                chk("hold_busy", BITSLIP_BUSY, 0);
            end
            chk("hold_cnt", SLIP_CNT, cnt);
            chk("hold_word", Q, word);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'hA, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 4'hA, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'hA, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'hA, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'hA, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'hA, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 4'hA, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'hA, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'hA, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'hA, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 4'hA, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 4'h3, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 4'h3, 1'b0};

        RST = 1'b1; D = 1'b0; EN = 1'b0; BITSLIP = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q", Q, 0);
        chk("rst_dv", DATA_VALID, 0);
        chk("rst_busy", BITSLIP_BUSY, 0);
        chk("rst_slip", SLIP_CNT, 0);
        RST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].d, tbl[i].en, 1'b0);
            chk($sformatf("vec%0d_q", i), Q, tbl[i].q);
            chk($sformatf("vec%0d_dv", i), DATA_VALID, tbl[i].dv);
        end

        for (int i = 0; i < 8; i++) begin
            send(1'b0);
            chk("aligned_dv", DATA_VALID, (i % 4) == 3);
            if ((i % 4) == 3) chk("aligned_q", Q, 4'hC);
        end

        do_slip(1, 3, 4'h9, 2'd1, 4'h0, 1'b1);
        do_slip(2, 2, 4'h3, 2'd2, 4'h0, 1'b0);
        do_slip(1, 3, 4'h6, 2'd3, 4'h0, 1'b0);
        do_slip(3, 5, 4'hC, 2'd0, 4'h6, 1'b0);
        do_slip(1, 3, 4'h9, 2'd1, 4'h0, 1'b0);

        send(1'b0);
        send(1'b0);
        send(1'b1);
        chk("pend_busy", BITSLIP_BUSY, 1);
        #1 RST = 1'b1;
        #1;
        chk("async_rst_q", Q, 0);
        chk("async_rst_dv", DATA_VALID, 0);
        chk("async_rst_busy", BITSLIP_BUSY, 0);
        chk("async_rst_slip", SLIP_CNT, 0);
        #1 RST = 1'b0;

        drive(1'b1, 1'b1, 1'b0);
        chk("post_rst_dv1", DATA_VALID, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("post_rst_dv2", DATA_VALID, 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("post_rst_dv3", DATA_VALID, 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("post_rst_dv4", DATA_VALID, 1);
        chk("post_rst_q", Q, 4'hB);
        chk("post_rst_busy", BITSLIP_BUSY, 0);
        chk("post_rst_slip", SLIP_CNT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
